sram_req_ctrl: RTL

- Request front-end sitting directly upstream of the 32-bit x 6-word single-port SRAM.
- Accepts read/write commands over a valid/ready interface and buffers them in a small command FIFO.
- Issues the commands to the SRAM as one-cycle wr/rd strobes.
- Returns read data, and out-of-range errors, over a valid/ready response interface.

---
 rtl/sram_req_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/sram_req_ctrl.sv
// Command FIFO plus issue FSM in front of a small single-port SRAM.
// Returns read data or out-of-range errors in command order.
module sram_req_ctrl #(
    parameter int DW         = 32,
    parameter int AW         = 3,
    parameter int MEM_DEPTH  = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          sram_wr,
    output logic          sram_rd,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_wdata,
    input  logic [DW-1:0] sram_rdata
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_CAP} state_t;

    cmd_t          fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;
    state_t        state_q;

    logic          rsp_valid_q, rsp_err_q, sram_wr_q, sram_rd_q;
    logic [DW-1:0] rsp_rdata_q, sram_wdata_q;
    logic [AW-1:0] sram_addr_q;

    cmd_t head;
    logic full, empty, push, pop, head_oor, slot_free, needs_rsp;

    // cmd_ready comes from the registered count only, so a full FIFO
    // never accepts even when it would pop in the same cycle.
    assign full      = (cnt_q == CW'(FIFO_DEPTH));
    assign empty     = (cnt_q == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;

    assign head      = fifo_q[rd_ptr_q];
    assign head_oor  = (32'(head.addr) >= MEM_DEPTH);
    assign slot_free = !rsp_valid_q || rsp_ready;
    assign needs_rsp = head_oor || !head.we;
    assign pop       = (state_q == IDLE) && !empty && (!needs_rsp || slot_free);

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= {cmd_we, cmd_addr, cmd_wdata};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
            sram_wr_q    <= 1'b0;
            sram_rd_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
        end else begin
            sram_wr_q <= 1'b0;
            sram_rd_q <= 1'b0;
            if (rsp_valid_q && rsp_ready) begin
                rsp_valid_q <= 1'b0;
                rsp_err_q   <= 1'b0;
                rsp_rdata_q <= '0;
            end
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        if (head_oor) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else if (head.we) begin
                            sram_wr_q    <= 1'b1;
                            sram_addr_q  <= head.addr;
                            sram_wdata_q <= head.wdata;
                        end else begin
                            sram_rd_q   <= 1'b1;
                            sram_addr_q <= head.addr;
                            state_q     <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: state_q <= RD_CAP;
                // slot was checked free at issue and nothing else loads it since
                RD_CAP: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= sram_rdata;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign sram_wr    = sram_wr_q;
    assign sram_rd    = sram_rd_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;

endmodule
